modn_cascade_counter: RTL and testbench
=======================================

Name: modn_cascade_counter

Overview:
- Parametrised successor to the fixed mod-7 counter: a chain of DIGITS cascaded modulo-MODULUS digits counting as one base-MODULUS number.
- Adds count enable, up/down direction, synchronous parallel load, and wrap or saturate mode.
- Adds a terminal-count flag and a registered wrap pulse for cascading into further blocks.
- Used as a general sequencer/timebase in lab datapaths, e.g. a two-digit mod-7 counter driving displays.

Parameters:
- MODULUS, 7, count base per digit; legal range 2..256.
- DIGITS, 2, number of cascaded digits; legal range 1..8.
- W (localparam), $clog2(MODULUS), bits per digit; not overridable.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  global reset; synchronous, active-high.
- enable  in  1  count enable; one step per cycle when high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- wrap  in  1  mode: 1 = wrap around at the end, 0 = saturate at the end.
- load  in  1  synchronous parallel load strobe.
- load_value  in  DIGITS*W  load data; digit i in bits [i*W +: W].
- value  out  DIGITS*W  current count; digit 0 is least significant.
- at_terminal  out  1  combinational: every digit is at the terminal value for the current direction.
- wrapped  out  1  registered one-cycle pulse, asserted the cycle after a full-chain wrap.

Behaviour:
- Reset: value = 0 and wrapped = 0 on the first posedge with reset high. reset has priority over all other inputs.
- Priority per cycle: reset > load > enable. With enable = 0 and load = 0, value holds.
- Load:
  - value <= load_value on the next edge; no count step that cycle.
  - Any digit >= MODULUS is clamped to MODULUS-1.
  - wrapped = 0 after a load.
- Terminal digit value is MODULUS-1 when up = 1 and 0 when up = 0.
- at_terminal = AND of all digits at terminal. It is combinational from value and up, and does not depend on enable.
- Cascade rule: digit i steps when enable = 1 and digits 0..i-1 are all at terminal. Digit 0 steps whenever enable = 1.
- A stepping digit moves as follows:
  - up = 1: goes to digit+1, or to 0 if it was MODULUS-1.
  - up = 0: goes to digit-1, or to MODULUS-1 if it was 0.
- Full-chain end (enable = 1 and at_terminal = 1):
  - wrap = 1: all digits roll over (up: all 0; down: all MODULUS-1), and wrapped = 1 for exactly the next cycle.
  - wrap = 0: value holds, and wrapped stays 0.
- wrapped is 0 in every cycle not covered above.
- Latency: one cycle from enable/load to value. at_terminal has zero latency relative to value.
- Direction change mid-count takes effect on the next step. No extra cycles, no glitch in value.
- Reset mid-count or mid-wrapped-pulse clears both outputs on that edge.
- All arithmetic is per digit at W bits. No digit ever holds a value >= MODULUS.

Decomposition:
- Package modn_counter_pkg holds:
  - function clamp_digit(value, modulus).
  - function digit_terminal(up, modulus), returning MODULUS-1 or 0.
- Sub-module modn_digit: one W-bit digit with inputs step, up, load, ld_val and output at_term.
- Top level instantiates DIGITS copies via generate, ANDs the at_term signals into the cascade enables, and owns the wrapped register and the saturate gating.

Test Plan (MODULUS = 7, DIGITS = 2, value = {d1, d0}):
1. Reset, then enable = 1, up = 1, wrap = 1 for 49 cycles:
   - value steps {0,0}..{6,6} then back to {0,0}.
   - at_terminal is high only at {6,6}.
   - wrapped is high only in the cycle after the return to {0,0}.
2. Reset, then enable = 1, up = 0, wrap = 1 for 1 cycle:
   - value = {6,6} and wrapped = 1 for one cycle.
   - Next cycle: value = {6,5} and wrapped = 0.
3. load = 1 with load_value = {3'd7, 3'd2} -> value = {6,2} (digit 1 clamped). Then enable = 1, up = 1 for 5 cycles -> value = {6,6}.
4. Saturate: load {6,5}, then wrap = 0, enable = 1, up = 1 for 3 cycles -> value = {6,6} and held, at_terminal = 1, wrapped never asserts.
5. Simultaneous events:
   - load and enable in the same cycle -> load value is taken, with no step.
   - reset asserted while wrapped = 1 -> value = {0,0} and wrapped = 0 on that edge.
6. Count up to {2,6}, drop enable for 3 cycles -> value holds at {2,6}. Then up = 0, enable = 1 for 1 cycle -> value = {2,5}.

Source files
------------

// File: rtl/modn_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : modn_counter_pkg
// Description : Shared helpers for the cascaded modulo-N counter. Covers
//               load-data clamping and the direction-dependent terminal
//               digit value.
// Revision    : 1.0 - initial release
// ============================================================================
package modn_counter_pkg;

    // Limits on the parameters of the cascaded counter
    localparam int unsigned c_MODULUS_MIN = 2;
    localparam int unsigned c_MODULUS_MAX = 256;
    localparam int unsigned c_DIGITS_MIN  = 1;
    localparam int unsigned c_DIGITS_MAX  = 8;

    // Clamp a loaded digit into the legal range 0..modulus-1
    function automatic int unsigned clamp_digit(input int unsigned value,
                                                input int unsigned modulus);
        if (value >= modulus) begin
            clamp_digit = modulus - 1;
        end else begin
            clamp_digit = value;
        end
    endfunction

    // Digit value at which a digit is at the end of its range for the
    // given direction: top of range counting up, zero counting down
    function automatic int unsigned digit_terminal(input logic        up,
                                                   input int unsigned modulus);
        if (up) begin
            digit_terminal = modulus - 1;
        end else begin
            digit_terminal = 0;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/modn_counter_digit.sv
`default_nettype none
// ============================================================================
// Module      : modn_digit
// Description : One modulo-MODULUS digit of the cascaded counter. Steps up or
//               down by one when 'step' is high, with load taking priority.
//               Flags when it sits at the terminal value for the current
//               direction.
// Revision    : 1.0 - initial release
// ============================================================================
module modn_digit
    import modn_counter_pkg::*;
#(
    parameter  int unsigned MODULUS = 7,
    localparam int unsigned W       = $clog2(MODULUS)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         step,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] digit,
    output logic         at_term
);

    localparam logic [W-1:0] c_MAX = W'(MODULUS - 1);

    logic [W-1:0] r_digit;
    logic [W-1:0] w_next;
    logic [W-1:0] w_ld_clamped;
    logic [W-1:0] w_term_val;

    // Out-of-range load data is pulled down to the largest legal digit so the
    // register can never hold a value >= MODULUS
    assign w_ld_clamped = W'(clamp_digit(32'(ld_val), MODULUS));
    assign w_term_val   = W'(digit_terminal(up, MODULUS));

    // Terminal flag follows the direction input immediately
    assign at_term = (r_digit == w_term_val);
    assign digit   = r_digit;

    // Next-digit selection: load beats step; stepping rolls over at the ends
    always_comb begin
        w_next = r_digit;
        if (load) begin
            w_next = w_ld_clamped;
        end else if (step) begin
            if (up) begin
                w_next = (r_digit == c_MAX) ? '0 : (r_digit + W'(1));
            end else begin
                w_next = (r_digit == '0) ? c_MAX : (r_digit - W'(1));
            end
        end
    end

    // Digit register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_digit <= '0;
        end else begin
            r_digit <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/modn_cascade_counter.sv
`default_nettype none
// ============================================================================
// Module      : modn_cascade_counter
// Description : DIGITS cascaded modulo-MODULUS digits counting as a single
//               base-MODULUS number. Provides enable, up/down, parallel load,
//               wrap/saturate mode, a terminal-count flag and a registered
//               one-cycle wrap pulse for cascading.
// Revision    : 1.0 - initial release
// ============================================================================
module modn_cascade_counter
    import modn_counter_pkg::*;
#(
    parameter  int unsigned MODULUS = 7,
    parameter  int unsigned DIGITS  = 2,
    localparam int unsigned W       = $clog2(MODULUS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                up,
    input  logic                wrap,
    input  logic                load,
    input  logic [DIGITS*W-1:0] load_value,
    output logic [DIGITS*W-1:0] value,
    output logic                at_terminal,
    output logic                wrapped
);

    // w_prefix[i] is high when digits 0..i-1 are all at terminal; the
    // extra top bit is the whole-chain terminal condition
    logic [DIGITS:0]   w_prefix;
    logic [DIGITS-1:0] w_term;
    logic [DIGITS-1:0] w_step;
    logic              w_sat_hold;
    logic              w_chain_wrap;
    logic              r_wrapped;

    assign w_prefix[0] = 1'b1;

    // One digit per position; each steps only when every lower digit is
    // at its terminal value, which forms the carry/borrow chain
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign w_prefix[i+1] = w_prefix[i] & w_term[i];
        assign w_step[i]     = enable & w_prefix[i] & ~w_sat_hold;

        modn_digit #(
            .MODULUS (MODULUS)
        ) u_digit (
            .clock   (clock),
            .reset   (reset),
            .step    (w_step[i]),
            .up      (up),
            .load    (load),
            .ld_val  (load_value[i*W +: W]),
            .digit   (value[i*W +: W]),
            .at_term (w_term[i])
        );
    end

    assign at_terminal = w_prefix[DIGITS];

    // In saturate mode a full chain at its end must not roll over, so all
    // step strobes are suppressed
    assign w_sat_hold   = at_terminal & ~wrap;
    assign w_chain_wrap = enable & at_terminal & wrap;

    // Wrap pulse: high for the single cycle after a full-chain rollover
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrapped <= 1'b0;
        end else if (load) begin
            r_wrapped <= 1'b0;
        end else begin
            r_wrapped <= w_chain_wrap;
        end
    end

    assign wrapped = r_wrapped;

endmodule
`default_nettype wire

// File: tb/tb_modn_cascade_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_modn_cascade_counter
// Description : Self-checking bench for modn_cascade_counter at MODULUS=7,
//               DIGITS=2. Table vectors carry hand-computed expectations;
//               longer runs use a whole-number reference model. Expected
//               results go through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modn_cascade_counter;

    localparam int unsigned MODULUS = 7;
    localparam int unsigned DIGITS  = 2;
    localparam int unsigned W       = 3;
    localparam int          c_TOP   = 48;  // largest count, {6,6}

    typedef struct {
        logic       r;
        logic       e;
        logic       u;
        logic       w;
        logic       l;
        logic [5:0] lv;
        logic [5:0] ev;
        logic       et;
        logic       ew;
    } vec_t;

    typedef struct {
        logic [5:0] v;
        logic       t;
        logic       w;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       up;
    logic       wrap;
    logic       load;
    logic [5:0] load_value;
    logic [5:0] value;
    logic       at_terminal;
    logic       wrapped;

    int   checks;
    int   failures;
    int   m_val;
    logic m_wr;
    exp_t exp_q[$];
    vec_t vecs[$];

    modn_cascade_counter #(
        .MODULUS (MODULUS),
        .DIGITS  (DIGITS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .up          (up),
        .wrap        (wrap),
        .load        (load),
        .load_value  (load_value),
        .value       (value),
        .at_terminal (at_terminal),
        .wrapped     (wrapped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog timeout value=%h required=finish", value);
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic r, input logic e, input logic u,
                                input logic w, input logic l,
                                input logic [2:0] l1, input logic [2:0] l0,
                                input logic [2:0] e1, input logic [2:0] e0,
                                input logic et, input logic ew);
        vec_t x;
        x.r = r; x.e = e; x.u = u; x.w = w; x.l = l;
        x.lv = {l1, l0};
        x.ev = {e1, e0};
        x.et = et;
        x.ew = ew;
        return x;
    endfunction

    // Reference model: the count is kept as one integer 0..48
    task automatic model_step(input logic r, input logic e, input logic u,
                              input logic w, input logic l,
                              input logic [5:0] lv, output exp_t x);
        int d0;
        int d1;
        if (r) begin
            m_val = 0;
            m_wr  = 1'b0;
        end else if (l) begin
            d0 = int'(lv[2:0]);
            d1 = int'(lv[5:3]);
            if (d0 > 6) d0 = 6;
            if (d1 > 6) d1 = 6;
            m_val = d1 * 7 + d0;
            m_wr  = 1'b0;
        end else if (e) begin
            if ((u && m_val == c_TOP) || (!u && m_val == 0)) begin
                if (w) begin
                    m_val = u ? 0 : c_TOP;
                    m_wr  = 1'b1;
                end else begin
                    m_wr  = 1'b0;
                end
            end else begin
                m_val = u ? m_val + 1 : m_val - 1;
                m_wr  = 1'b0;
            end
        end else begin
            m_wr = 1'b0;
        end
        x.v = {3'(m_val / 7), 3'(m_val % 7)};
        x.t = u ? (m_val == c_TOP) : (m_val == 0);
        x.w = m_wr;
    endtask

    task automatic check1(input string tag, input logic [5:0] got,
                          input logic [5:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", tag, got, req);
        end
    endtask

    // Drive one cycle, push the expectation, then pop and compare after the edge
    task automatic apply(input logic r, input logic e, input logic u,
                         input logic w, input logic l, input logic [5:0] lv,
                         input logic use_given, input exp_t given,
                         input string tag);
        exp_t m;
        exp_t x;
        @(negedge clock);
        reset = r; enable = e; up = u; wrap = w; load = l; load_value = lv;
        model_step(r, e, u, w, l, lv, m);
        exp_q.push_back(use_given ? given : m);
        @(posedge clock);
        #1;
        x = exp_q.pop_front();
        check1({tag, " value"},       value,               x.v);
        check1({tag, " at_terminal"}, {5'd0, at_terminal}, {5'd0, x.t});
        check1({tag, " wrapped"},     {5'd0, wrapped},     {5'd0, x.w});
    endtask

    task automatic model_run(input logic r, input logic e, input logic u,
                             input logic w, input logic l, input logic [5:0] lv,
                             input string tag);
        exp_t dummy;
        dummy.v = '0; dummy.t = 1'b0; dummy.w = 1'b0;
        apply(r, e, u, w, l, lv, 1'b0, dummy, tag);
    endtask

    initial begin
        exp_t g;
        checks = 0; failures = 0; m_val = 0; m_wr = 1'b0;
        reset = 1'b1; enable = 1'b0; up = 1'b1; wrap = 1'b1; load = 1'b0;
        load_value = '0;

        // Hand-computed vectors: r e u w l load{d1,d0} expect{d1,d0} term wrapped
        vecs.push_back(mk(1,0,1,1,0, 0,0, 0,0, 0,0));  // reset state
        vecs.push_back(mk(0,0,1,1,1, 7,2, 6,2, 0,0));  // load with clamp
        vecs.push_back(mk(0,1,1,0,0, 0,0, 6,3, 0,0));
        vecs.push_back(mk(0,1,1,0,0, 0,0, 6,4, 0,0));
        vecs.push_back(mk(0,1,1,0,0, 0,0, 6,5, 0,0));
        vecs.push_back(mk(0,1,1,0,0, 0,0, 6,6, 1,0));
        vecs.push_back(mk(0,1,1,0,0, 0,0, 6,6, 1,0));  // saturated
        vecs.push_back(mk(0,0,1,0,1, 6,5, 6,5, 0,0));  // saturate sequence
        vecs.push_back(mk(0,1,1,0,0, 0,0, 6,6, 1,0));
        vecs.push_back(mk(0,1,1,0,0, 0,0, 6,6, 1,0));
        vecs.push_back(mk(0,1,1,0,0, 0,0, 6,6, 1,0));
        vecs.push_back(mk(0,1,1,1,1, 1,3, 1,3, 0,0));  // load beats enable
        vecs.push_back(mk(0,1,1,1,0, 0,0, 1,4, 0,0));
        vecs.push_back(mk(0,0,1,1,1, 6,6, 6,6, 1,0));
        vecs.push_back(mk(0,1,1,1,1, 6,6, 6,6, 1,0));  // load beats wrap
        vecs.push_back(mk(0,1,1,1,0, 0,0, 0,0, 0,1));  // up wrap
        vecs.push_back(mk(0,1,1,1,0, 0,0, 0,1, 0,0));
        vecs.push_back(mk(0,0,0,1,1, 0,0, 0,0, 1,0));
        vecs.push_back(mk(0,1,0,1,0, 0,0, 6,6, 0,1));  // down wrap
        vecs.push_back(mk(1,1,0,1,0, 0,0, 0,0, 1,0));  // reset during pulse

        foreach (vecs[i]) begin
            g.v = vecs[i].ev; g.t = vecs[i].et; g.w = vecs[i].ew;
            apply(vecs[i].r, vecs[i].e, vecs[i].u, vecs[i].w, vecs[i].l,
                  vecs[i].lv, 1'b1, g, $sformatf("vec%0d", i));
        end

        // Full up count through wrap and one step beyond
        model_run(1, 0, 1, 1, 0, 6'd0, "upcnt_reset");
        for (int i = 0; i < 50; i++) begin
            model_run(0, 1, 1, 1, 0, 6'd0, $sformatf("upcnt%0d", i));
        end

        // Down from reset wraps immediately
        model_run(1, 0, 0, 1, 0, 6'd0, "down_reset");
        g.v = {3'd6, 3'd6}; g.t = 1'b0; g.w = 1'b1;
        apply(0, 1, 0, 1, 0, 6'd0, 1'b1, g, "down_wrap");
        g.v = {3'd6, 3'd5}; g.t = 1'b0; g.w = 1'b0;
        apply(0, 1, 0, 1, 0, 6'd0, 1'b1, g, "down_step");

        // Count to {2,6}, hold with enable low, then one step down
        model_run(1, 0, 1, 1, 0, 6'd0, "hold_reset");
        for (int i = 0; i < 20; i++) begin
            model_run(0, 1, 1, 1, 0, 6'd0, $sformatf("hold_cnt%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            g.v = {3'd2, 3'd6}; g.t = 1'b0; g.w = 1'b0;
            apply(0, 0, 1, 1, 0, 6'd0, 1'b1, g, $sformatf("hold%0d", i));
        end
        g.v = {3'd2, 3'd5}; g.t = 1'b0; g.w = 1'b0;
        apply(0, 1, 0, 1, 0, 6'd0, 1'b1, g, "hold_down");

        // at_terminal follows up with no clock edge
        g.v = {3'd6, 3'd6}; g.t = 1'b1; g.w = 1'b0;
        apply(0, 0, 1, 1, 1, {3'd6, 3'd6}, 1'b1, g, "term_load");
        @(negedge clock);
        load = 1'b0; up = 1'b0;
        #1;
        check1("term_dir_down", {5'd0, at_terminal}, 6'd0);
        up = 1'b1;
        #1;
        check1("term_dir_up", {5'd0, at_terminal}, 6'd1);

        // Random mix against the model
        for (int i = 0; i < 300; i++) begin
            model_run(($urandom % 40) == 0, ($urandom % 4) != 0,
                      ($urandom % 5) != 0, 1'($urandom), ($urandom % 8) == 0,
                      6'($urandom), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
